md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit living in the EX stage, alongside the ALU, and feeding the EX/MA pipeline register. It executes mult/multu/div/divu with fixed multi-cycle latency, owns the HI/LO registers, and services mfhi/mflo/mthi/mtlo. It exports a busy flag that the hazard unit uses to stall md-class instructions in EX. A pending exception/interrupt request suppresses any new operation from the instruction being flushed.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled)
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; launches the operation selected by mdOp
- mdOp  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 0 none
- A  in  32  rs operand, already forwarded
- B  in  32  rt operand, already forwarded
- req  in  1  exception/interrupt taken this cycle; EX instruction is being flushed
- busy  out  1  operation in progress
- md_out  out  32  HI for mdOp=5, LO for mdOp=6, else 0 (combinational)

## Operation

- State: HI[31:0], LO[31:0], cnt[3:0], busy, pending op, pending result (64 bit).
- Launch: start=1, busy=0, req=0 and mdOp in {1,2,3,4} (or {9,10} when enabled).
  - Result is computed from A/B sampled at the launch edge.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES, and busy is set.
- Arithmetic:
  - mult: signed 32x32 to 64; {HI,LO} = product.
  - multu: unsigned 32x32 to 64; {HI,LO} = product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - Divide by zero (B=0): HI and LO are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Countdown: while busy, cnt decrements each cycle. On the edge where cnt==1, HI/LO are written, busy is cleared and cnt becomes 0.
- mthi/mtlo: mdOp=7 or 8 with busy=0 and req=0 writes A into HI or LO at the next edge. start is not required.
- mfhi/mflo: md_out reads HI/LO combinationally. No bypass from in-flight results, because the hazard unit stalls while busy.
- Any start, mthi or mtlo arriving while busy=1 is ignored. The hazard unit guarantees this does not occur.
- req=1 blocks launch and mthi/mtlo in that cycle. An operation already in flight runs to completion and commits, since it belongs to an older, committed instruction.
- Stall rule for the hazard unit: stall the EX-stage md instruction (mdOp 1..10) while (busy | start).

## Timing

- Reset values: HI=0, LO=0, cnt=0, busy=0. Hence md_out=0.
- Start sampled at edge T:
  - busy=1 from T through T+N (N = configured cycles). Visible busy-high cycles are N.
  - HI/LO are updated at edge T+N and readable via md_out from that cycle on.
  - busy reads 0 in the cycle after the last busy-high cycle.
- Back-to-back: a new start is accepted in the first cycle where busy=0.
- mthi/mtlo: one-edge latency; the value is visible on md_out the following cycle.
- Reset asserted mid-operation: the operation is aborted immediately (asynchronous) and HI/LO return to 0. No commit occurs after reset is released.
- Simultaneous completion edge and a new mthi/mtlo: not possible, because busy=1 blocks the mthi/mtlo. The completion write takes effect.

## Configuration

- MDU_MADD_EN defined:
  - mdOp 9 (madd): {HI,LO} += signed A*B.
  - mdOp 10 (maddu): {HI,LO} += unsigned A*B.
  - 64-bit wrap-around. Accumulation uses the HI/LO values at the launch edge. Latency is MULT_CYCLES.
- MDU_MADD_EN undefined: mdOp 9 and 10 are treated as none. There is no launch, busy stays 0 and HI/LO are unchanged.

## Test plan

- Reset, then pulse start with mult, A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- divu with A=7, B=2, then div with A=-7, B=2 -> busy high 10 cycles each. divu gives LO=3, HI=1. div gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. The second start is accepted in the first busy=0 cycle.
- mthi with A=0x12345678, next cycle mflo/mfhi -> md_out=0x12345678 for mfhi. A div with B=0 afterwards leaves HI=0x12345678, LO unchanged.
- start (multu) together with req=1 -> busy stays 0 and HI/LO are unchanged. Separately, req=1 during an in-flight mult -> the mult still commits.
- Assert reset in the 3rd busy cycle of a div -> busy=0, HI=LO=0 immediately, and nothing is written after release.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then madd with A=1, B=1 -> HI=1, LO=0. Without the macro the same stimulus leaves HI/LO unchanged and busy=0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO, fixed-latency countdown.
// Define MDU_MADD_EN to enable madd/maddu (mdOp 9/10) accumulation into {HI,LO}.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        busy,
    output logic [31:0] md_out
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // Unsigned divide, returns {remainder, quotient}.
    function automatic logic [63:0] divu_fn(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        if (d == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    function automatic logic [63:0] div_fn(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] n_mag;
        logic [31:0] d_mag;
        logic [63:0] rq;
        logic [31:0] q;
        logic [31:0] r;
        n_mag = n[31] ? (32'd0 - n) : n;
        d_mag = d[31] ? (32'd0 - d) : d;
        rq    = divu_fn(n_mag, d_mag);
        q     = (n[31] ^ d[31]) ? (32'd0 - rq[31:0]) : rq[31:0];
        r     = n[31] ? (32'd0 - rq[63:32]) : rq[63:32];
        return {r, q};
    endfunction

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [63:0] pend_res_r;
    logic        pend_wr_r;

    logic [63:0] prod_signed_s;
    logic [63:0] prod_unsigned_s;
    logic [63:0] op_res_s;
    logic        op_wr_s;
    logic [3:0]  op_cnt_s;
    logic        op_valid_s;
    logic        launch_s;
    logic        move_ok_s;

    assign prod_signed_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_unsigned_s = {32'd0, A} * {32'd0, B};
    assign launch_s        = start & ~busy_r & ~req & op_valid_s;
    assign move_ok_s       = ~busy_r & ~req;
    assign busy            = busy_r;

    // Decode the launch candidate: result, commit enable (divide by zero commits nothing), latency.
    always_comb begin
        op_res_s   = 64'd0;
        op_wr_s    = 1'b0;
        op_cnt_s   = 4'd0;
        op_valid_s = 1'b0;
        case (mdOp)
            OP_MULT: begin
                op_res_s = prod_signed_s; op_wr_s = 1'b1; op_cnt_s = MULT_CNT; op_valid_s = 1'b1;
            end
            OP_MULTU: begin
                op_res_s = prod_unsigned_s; op_wr_s = 1'b1; op_cnt_s = MULT_CNT; op_valid_s = 1'b1;
            end
            OP_DIV: begin
                op_res_s = div_fn(A, B); op_wr_s = (B != 32'd0); op_cnt_s = DIV_CNT; op_valid_s = 1'b1;
            end
            OP_DIVU: begin
                op_res_s = divu_fn(A, B); op_wr_s = (B != 32'd0); op_cnt_s = DIV_CNT; op_valid_s = 1'b1;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                op_res_s = {hi_r, lo_r} + prod_signed_s; op_wr_s = 1'b1; op_cnt_s = MULT_CNT; op_valid_s = 1'b1;
            end
            OP_MADDU: begin
                op_res_s = {hi_r, lo_r} + prod_unsigned_s; op_wr_s = 1'b1; op_cnt_s = MULT_CNT; op_valid_s = 1'b1;
            end
`endif
            default: begin
                op_valid_s = 1'b0;
            end
        endcase
    end

    // HI/LO, countdown and pending-result state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            cnt_r      <= 4'd0;
            busy_r     <= 1'b0;
            pend_res_r <= 64'd0;
            pend_wr_r  <= 1'b0;
        end else if (busy_r) begin
            if (cnt_r == 4'd1) begin
                busy_r <= 1'b0;
                cnt_r  <= 4'd0;
                if (pend_wr_r) begin
                    {hi_r, lo_r} <= pend_res_r;
                end
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end else if (launch_s) begin
            pend_res_r <= op_res_s;
            pend_wr_r  <= op_wr_s;
            cnt_r      <= op_cnt_s;
            busy_r     <= 1'b1;
        end else if (move_ok_s && mdOp == OP_MTHI) begin
            hi_r <= A;
        end else if (move_ok_s && mdOp == OP_MTLO) begin
            lo_r <= A;
        end
    end

    // Register read port for mfhi/mflo.
    always_comb begin
        case (mdOp)
            OP_MFHI: md_out = hi_r;
            OP_MFLO: md_out = lo_r;
            default: md_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {HI,LO} queued at launch, compared after completion.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic [31:0] md_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] exp_q[$];
    int          madd_n;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .mdOp(mdOp), .A(A), .B(B),
        .req(req), .busy(busy), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] acc;
        acc = {hi, lo};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            4'd1: return sa * sb;
            4'd2: return {32'd0, a} * {32'd0, b};
            4'd3: begin
                if (b == 32'd0) return acc;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            4'd7: return {a, lo};
            4'd8: return {hi, a};
`ifdef MDU_MADD_EN
            4'd9:  return acc + 64'(sa * sb);
            4'd10: return acc + ({32'd0, a} * {32'd0, b});
`endif
            default: return acc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        mdOp = 4'd5;
        #1 hi = md_out;
        mdOp = 4'd6;
        #1 lo = md_out;
        mdOp = 4'd0;
    endtask

    task automatic compare_hilo(input string tag);
        logic [63:0] e;
        logic [31:0] hi;
        logic [31:0] lo;
        check_val({tag, ".queue"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_hilo(hi, lo);
            check_val({tag, ".hi"}, hi, e[63:32]);
            check_val({tag, ".lo"}, lo, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic count_busy(input string tag, input int first, input int n_exp);
        int n;
        n = first;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check_val({tag, ".busy_cycles"}, 32'(n), 32'(n_exp));
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input int n_exp);
        if (r) exp_q.push_back({m_hi, m_lo});
        else   exp_q.push_back(model(op, a, b, m_hi, m_lo));
        start = 1'b1; mdOp = op; A = a; B = b; req = r;
        tick();
        start = 1'b0; mdOp = 4'd0; req = 1'b0;
        count_busy(tag, 0, n_exp);
        compare_hilo(tag);
    endtask

    task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] a);
        exp_q.push_back(model(op, a, 32'd0, m_hi, m_lo));
        mdOp = op; A = a;
        tick();
        mdOp = 4'd0;
        compare_hilo(tag);
    endtask

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; req = 1'b0; mdOp = 4'd0; A = 32'd0; B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("reset.busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check_val("reset.hi", hi, 32'd0);
        check_val("reset.lo", lo, 32'd0);

        do_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 5);
        do_op("divu", 4'd4, 32'd7, 32'd2, 1'b0, 10);
        do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10);
        do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10);

        move_to("mthi", 4'd7, 32'h1234_5678);
        do_op("div_by_zero", 4'd3, 32'd99, 32'd0, 1'b0, 10);
        move_to("mtlo", 4'd8, 32'hCAFE_F00D);
        do_op("multu_req", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);

        // req raised while a mult is already in flight must not cancel it
        exp_q.push_back(model(4'd1, 32'hFFFF_FFFD, 32'd7, m_hi, m_lo));
        start = 1'b1; mdOp = 4'd1; A = 32'hFFFF_FFFD; B = 32'd7;
        tick();
        start = 1'b0; mdOp = 4'd0; req = 1'b1;
        tick();
        req = 1'b0;
        count_busy("mult_inflight_req", 1, 5);
        compare_hilo("mult_inflight_req");

        for (int i = 0; i < 6; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (rop >= 4'd3) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
            do_op("random", rop, ra, rb, 1'b0, (rop <= 4'd2) ? 5 : 10);
        end

        // asynchronous reset in the third busy cycle of a divide
        move_to("pre_reset_hi", 4'd7, 32'hA5A5_0001);
        start = 1'b1; mdOp = 4'd3; A = 32'd1000; B = 32'd3;
        tick();
        start = 1'b0; mdOp = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_val("abort.busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check_val("abort.hi", hi, 32'd0);
        check_val("abort.lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (15) tick();
        check_val("post_abort.busy", {31'd0, busy}, 32'd0);
        read_hilo(hi, lo);
        check_val("post_abort.hi", hi, 32'd0);
        check_val("post_abort.lo", lo, 32'd0);

`ifdef MDU_MADD_EN
        madd_n = 5;
`else
        madd_n = 0;
`endif
        move_to("madd_pre_hi", 4'd7, 32'd0);
        move_to("madd_pre_lo", 4'd8, 32'hFFFF_FFFF);
        do_op("madd", 4'd9, 32'd1, 32'd1, 1'b0, madd_n);
        do_op("maddu", 4'd10, 32'hFFFF_FFFF, 32'd2, 1'b0, madd_n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
